// File: rtl/pmem_arbiter.sv
// Program-memory read-port arbiter between instruction fetch and the load unit.
// Define PMEM_ARB_RR_EN for round-robin arbitration; the default is load-first priority with fetch starvation relief.
module pmem_arbiter #(
    parameter int WORD_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_fetch_req,
    input  logic [ADDR_WIDTH-1:0] in_fetch_addr,
    input  logic                  in_fetch_flush,
    output logic                  out_fetch_gnt,
    output logic                  out_fetch_valid,
    output logic [WORD_WIDTH-1:0] out_fetch_word,
    input  logic                  in_load_req,
    input  logic [ADDR_WIDTH-1:0] in_load_addr,
    output logic                  out_load_gnt,
    output logic                  out_load_valid,
    output logic [WORD_WIDTH-1:0] out_load_word,
    output logic [ADDR_WIDTH-1:0] out_pmem_addr,
    input  logic [WORD_WIDTH-1:0] in_pmem_word
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_t;

    owner_t                owner_q, owner_d;
    logic                  fetchGnt, loadGnt;
    logic                  fetchValid, loadValid;
    logic [WORD_WIDTH-1:0] holdFetch_q, holdFetch_d;
    logic [WORD_WIDTH-1:0] holdLoad_q, holdLoad_d;

`ifdef PMEM_ARB_RR_EN
    logic lastGrantFetch_q, lastGrantFetch_d;

    // On contention the requester that did not win last time goes next.
    always_comb begin
        fetchGnt = 1'b0;
        loadGnt  = 1'b0;
        if (reset_n) begin
            if (in_fetch_req && in_load_req) begin
                fetchGnt = !lastGrantFetch_q;
                loadGnt  = lastGrantFetch_q;
            end else begin
                fetchGnt = in_fetch_req;
                loadGnt  = in_load_req;
            end
        end
    end

    always_comb begin
        lastGrantFetch_d = lastGrantFetch_q;
        if (fetchGnt || loadGnt) begin
            lastGrantFetch_d = fetchGnt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lastGrantFetch_q <= 1'b1;
        end else begin
            lastGrantFetch_q <= lastGrantFetch_d;
        end
    end
`else
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_q, starve_d;
    logic          fetchForced;

    // Load normally wins; fetch takes over once it has been denied STARVE_LIMIT cycles in a row.
    assign fetchForced = (starve_q == CW'(STARVE_LIMIT));

    always_comb begin
        loadGnt  = reset_n && in_load_req && !(in_fetch_req && fetchForced);
        fetchGnt = reset_n && in_fetch_req && !loadGnt;
    end

    always_comb begin
        starve_d = '0;
        if (in_fetch_req && !fetchGnt) begin
            starve_d = fetchForced ? starve_q : starve_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    assign out_fetch_gnt = fetchGnt;
    assign out_load_gnt  = loadGnt;

    always_comb begin
        out_pmem_addr = '0;
        if (fetchGnt) begin
            out_pmem_addr = in_fetch_addr;
        end else if (loadGnt) begin
            out_pmem_addr = in_load_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (fetchGnt) begin
            owner_d = OWN_FETCH;
        end else if (loadGnt) begin
            owner_d = OWN_LOAD;
        end
    end

    // A flushed fetch response still consumes the memory slot but is neither delivered nor held.
    always_comb begin
        fetchValid = (owner_q == OWN_FETCH) && !in_fetch_flush;
        loadValid  = (owner_q == OWN_LOAD);
    end

    assign out_fetch_valid = fetchValid;
    assign out_load_valid  = loadValid;
    assign out_fetch_word  = fetchValid ? in_pmem_word : holdFetch_q;
    assign out_load_word   = loadValid ? in_pmem_word : holdLoad_q;

    always_comb begin
        holdFetch_d = fetchValid ? in_pmem_word : holdFetch_q;
        holdLoad_d  = loadValid ? in_pmem_word : holdLoad_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            holdFetch_q <= '0;
            holdLoad_q  <= '0;
        end else begin
            holdFetch_q <= holdFetch_d;
            holdLoad_q  <= holdLoad_d;
        end
    end

endmodule
